// File: rtl/wb_accel_bridge_if.sv
// ---------------------------------------------------------------------------
// wb_accel_bridge_if
//
// Single-beat classic Wishbone bus bundle, used on both sides of
// wb_accel_bridge.
//
// Signals:
//   adr    address                         (master -> slave)
//   dat_w  write data                      (master -> slave)
//   sel    byte selects, DATA_WIDTH/8 bits (master -> slave)
//   we     write enable                    (master -> slave)
//   cyc    bus cycle                       (master -> slave)
//   stb    strobe                          (master -> slave)
//   dat_r  read data                       (slave -> master)
//   ack    normal termination              (slave -> master)
//   err    error termination               (slave -> master)
//
// Modports:
//   master  the side that issues requests
//   slave   the side that answers requests
// ---------------------------------------------------------------------------
interface wb_accel_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat_w;
    logic [DATA_WIDTH-1:0]   dat_r;
    logic [DATA_WIDTH/8-1:0] sel;
    logic                    we;
    logic                    cyc;
    logic                    stb;
    logic                    ack;
    logic                    err;

    modport master (
        output adr, dat_w, sel, we, cyc, stb,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc, stb,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_accel_bridge.sv
// ---------------------------------------------------------------------------
// wb_accel_bridge
//
// Registered Wishbone bridge between the network adapter's Wishbone master
// and an accelerator slave. The bridge takes one single-beat classic request,
// re-issues it downstream from registers, and returns exactly one registered
// ack or err pulse upstream.
//
// Optional feature macro: WB_ACCEL_BRIDGE_TIMEOUT_EN
//   defined   : a timer aborts a downstream request held for TIMEOUT_CYCLES
//               cycles and reports it upstream as err; timeout_count counts
//               these events, saturating at 255.
//   undefined : no timer, ISSUE waits for ack/err indefinitely, and
//               timeout_count is tied to 0.
//
// Ports:
//   clk            single clock
//   rst            synchronous, active-high reset
//   wbs            slave modport, facing the network adapter master
//   wbm            master modport, facing the accelerator slave
//   busy           high whenever the FSM is not IDLE
//   timeout_count  saturating count of timeouts since reset
// ---------------------------------------------------------------------------
module wb_accel_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    wb_accel_bridge_if.slave         wbs,
    wb_accel_bridge_if.master        wbm,
    output logic                     busy,
    output logic [7:0]               timeout_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    logic [1:0]            state_q,   state_d;
    logic [ADDR_WIDTH-1:0] adr_q,     adr_d;
    logic [DATA_WIDTH-1:0] wdat_q,    wdat_d;
    logic [SEL_WIDTH-1:0]  sel_q,     sel_d;
    logic                  we_q,      we_d;
    logic                  req_q,     req_d;
    logic                  drop_q,    drop_d;
    logic                  ack_q,     ack_d;
    logic                  err_q,     err_d;
    logic [DATA_WIDTH-1:0] rdat_q,    rdat_d;

`ifdef WB_ACCEL_BRIDGE_TIMEOUT_EN
    localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TIMER_W-1:0]    timer_q,   timer_d;
    logic [7:0]            to_cnt_q,  to_cnt_d;
`else
    // The timeout length only matters when the timer is built in.
    logic                  unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES < 2);
`endif

    // Next-state logic. Upstream ack/err pulses are produced only on the
    // ISSUE -> RESP transition, so they are high for exactly the RESP cycle.
    // cyc and stb share one flop because they always move together.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        req_d   = req_q;
        drop_d  = drop_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdat_d  = rdat_q;
`ifdef WB_ACCEL_BRIDGE_TIMEOUT_EN
        timer_d  = timer_q;
        to_cnt_d = to_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (wbs.cyc && wbs.stb) begin
                    adr_d   = wbs.adr;
                    wdat_d  = wbs.dat_w;
                    sel_d   = wbs.sel;
                    we_d    = wbs.we;
                    req_d   = 1'b1;
                    drop_d  = 1'b0;
                    state_d = ST_ISSUE;
`ifdef WB_ACCEL_BRIDGE_TIMEOUT_EN
                    timer_d = '0;
`endif
                end
            end
            ST_ISSUE: begin
                // An upstream abort in the final ISSUE cycle must still
                // suppress the response, hence the combined drop value.
                drop_d = drop_q | ~wbs.cyc;
                if (wbm.err) begin
                    req_d   = 1'b0;
                    err_d   = ~drop_d;
                    rdat_d  = '0;
                    state_d = ST_RESP;
                end else if (wbm.ack) begin
                    req_d   = 1'b0;
                    ack_d   = ~drop_d;
                    rdat_d  = wbm.dat_r;
                    state_d = ST_RESP;
                end
`ifdef WB_ACCEL_BRIDGE_TIMEOUT_EN
                else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    req_d   = 1'b0;
                    err_d   = ~drop_d;
                    rdat_d  = '0;
                    state_d = ST_RESP;
                    if (to_cnt_q != 8'hFF) begin
                        to_cnt_d = to_cnt_q + 8'd1;
                    end
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
`endif
            end
            ST_RESP: begin
                // stb may still be high from the finished beat; it is
                // deliberately not looked at here.
                state_d = ST_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, all cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
            drop_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            req_q   <= req_d;
            drop_q  <= drop_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
        end
    end

`ifdef WB_ACCEL_BRIDGE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q  <= '0;
            to_cnt_q <= '0;
        end else begin
            timer_q  <= timer_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    assign timeout_count = to_cnt_q;
`else
    assign timeout_count = 8'd0;
`endif

    assign wbm.adr   = adr_q;
    assign wbm.dat_w = wdat_q;
    assign wbm.sel   = sel_q;
    assign wbm.we    = we_q;
    assign wbm.cyc   = req_q;
    assign wbm.stb   = req_q;

    assign wbs.ack   = ack_q;
    assign wbs.err   = err_q;
    assign wbs.dat_r = rdat_q;

    assign busy      = (state_q != ST_IDLE);

endmodule
